// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-coded pointer counter: widths, the counter
// operation encoding and binary/Gray conversion helpers.
package gray_pkg;

    localparam int GRAY_W     = 4;
    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_UP   = 3'd3,
        OP_DN   = 3'd4
    } cnt_op_e;

    // Helpers work on a wide word; callers zero-extend and truncate to their width.
    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 32'd1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin = gray;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational W-bit binary-to-Gray encoder.
module gray_enc
    import gray_pkg::*;
#(
    parameter int W = GRAY_W
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = W'(bin2gray(gray_word_t'(bin_i)));

endmodule

// File: rtl/gray_ptr_counter.sv
// Up/down binary counter with registered Gray output, wrap strobe and
// Gray-change strobe. Gray is encoded from the next-state value, then flopped.
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int           W       = GRAY_W,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up_dn,
    output logic [W-1:0] b,
    output logic [W-1:0] g,
    output logic         wrap,
    output logic         g_chg
);

    localparam logic [W-1:0] MAX_VAL  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
    localparam logic [W-1:0] ONE_VAL  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] RST_GRAY = W'(bin2gray(gray_word_t'(RST_VAL)));

    cnt_op_e      op_s;
    logic [W-1:0] b_d, g_d;
    logic         wrap_d, g_chg_d;
    logic [W-1:0] b_q, g_q;
    logic         wrap_q, g_chg_q;

    // Priority decode of the control inputs: clr > load > en.
    always_comb begin
        op_s = OP_HOLD;
        if (clr) begin
            op_s = OP_CLR;
        end else if (load) begin
            op_s = OP_LOAD;
        end else if (en) begin
            op_s = up_dn ? OP_UP : OP_DN;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next binary value and wrap detection for the selected operation.
    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        case (op_s)
            OP_CLR:  b_d = RST_VAL;
            OP_LOAD: b_d = load_val;
            OP_UP: begin
                b_d    = b_q + ONE_VAL;
                wrap_d = (b_q == MAX_VAL);
            end
            OP_DN: begin
                b_d    = b_q - ONE_VAL;
                wrap_d = (b_q == ZERO_VAL);
            end
            OP_HOLD: b_d = b_q;
            default: begin
                b_d    = b_q;
                wrap_d = 1'b0;
            end
        endcase
    end

    gray_enc #(.W(W)) u_enc (
        .bin_i  (b_d),
        .gray_o (g_d)
    );

    // A load or clear to the current value leaves Gray untouched and raises no strobe.
    assign g_chg_d = (g_d != g_q);

    // Output flops; all outputs come straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q     <= RST_VAL;
            g_q     <= RST_GRAY;
            wrap_q  <= 1'b0;
            g_chg_q <= 1'b0;
        end else begin
            b_q     <= b_d;
            g_q     <= g_d;
            wrap_q  <= wrap_d;
            g_chg_q <= g_chg_d;
        end
    end

    assign b     = b_q;
    assign g     = g_q;
    assign wrap  = wrap_q;
    assign g_chg = g_chg_q;

endmodule

// File: doc/gray_ptr_counter.md
Name: gray_ptr_counter

Overview:
Up/down binary counter with a registered Gray-code output, used as the source stage that feeds Gray-coded values to downstream logic (clock-domain-crossing pointers, position encoders).
- Both binary and Gray values come straight from flops, so the Gray bus is glitch-free and changes by exactly one bit per count step.
- Supports synchronous clear, parallel load, count enable and direction, plus a one-cycle wrap strobe.

Parameters:
- W, 4, counter and Gray width in bits (W >= 2)
- RST_VAL, 0, binary reset/clear value (W bits); the Gray reset value is derived from it

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear to RST_VAL
- load  input  1  synchronous parallel load
- load_val  input  W  binary value for load
- en  input  1  count enable
- up_dn  input  1  1 = increment, 0 = decrement
- b  output  W  registered binary count
- g  output  W  registered Gray code of b
- wrap  output  1  one-cycle pulse: the count just wrapped
- g_chg  output  1  one-cycle pulse: g changed on this edge

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-count): b = RST_VAL, g = gray(RST_VAL), wrap = 0, g_chg = 0. All outputs hold while rst_n is low.
- Release of reset is synchronous in effect: the first count happens at the first rising clk edge on which rst_n is high and en is high.
- gray(x) = x ^ (x >> 1), computed on the next-state binary value and registered, so g always equals gray(b) in the same cycle.
- Priority per rising edge is clr > load > en; otherwise hold.
  - clr: b_next = RST_VAL; wrap = 0.
  - load: b_next = load_val; wrap = 0.
  - en && up_dn: b_next = b + 1 mod 2^W. wrap = 1 when b was 2^W-1 (b_next = 0).
  - en && !up_dn: b_next = b - 1 mod 2^W. wrap = 1 when b was 0 (b_next = 2^W-1).
  - Hold: b, g unchanged; wrap = 0.
- g_chg = 1 on the cycle after any edge where g_next != g, covering count, load, and clr to a different value. A load or clr of the current value gives g_chg = 0.
- Latency: controls sampled at edge N appear on b/g/wrap/g_chg after edge N. No combinational path from inputs to outputs.
- Single-bit property: a count step (not load or clr) changes exactly one bit of g, wrap steps included.
- A direction change while en = 1 takes effect immediately on that edge; there are no dead cycles.
- Inputs are assumed synchronous to clk; the block contains no synchronizers.

Decomposition:
- Shared package gray_pkg holds:
  - default width constant GRAY_W = 4
  - function bin2gray(logic [W-1:0])
  - function gray2bin, for verification reference models
- Natural sub-module: gray_enc, a combinational W-bit binary-to-Gray encoder instantiated on the next-state path.
- The counter/priority logic and output flops live in gray_ptr_counter.

Test Plan:
- Reset: rst_n = 0 mid-count at b = 4'b0110, asynchronous to clk -> b = 0000, g = 0000, wrap = 0, g_chg = 0 immediately, without waiting for an edge.
- Up-count full cycle: en = 1, up_dn = 1 for 17 clocks from 0 -> g runs 0000, 0001, 0011, 0010, 0110, ..., 1000, 0000. Check every step:
  - exactly one g bit changes
  - wrap = 1 only on the 1111 -> 0000 step
  - g_chg = 1 on every cycle
- Down-count across zero: from b = 0001 with up_dn = 0, two clocks -> b = 0000 then 1111, g = 0000 then 1000, wrap = 1 on the second step only.
- Priority:
  - clr = 1, load = 1, load_val = 1010, en = 1 at b = 0101 -> b = 0000.
  - Next cycle load = 1, en = 1 -> b = 1010, g = 1111, wrap = 0.
- Hold and no-change: en = 0 for 5 clocks at b = 0111 -> b/g stable, g_chg = 0. Then load_val = 0111 with load = 1 -> g_chg stays 0.
- Direction flip: at b = 0011 alternate up_dn 1, 0, 1 with en = 1 -> b = 0100, 0011, 0100 with g = 0110, 0010, 0110, and no idle cycles.
